qarctan_two_inputs: RTL and testbench
=====================================

QARCTAN_TWO_INPUTS -- requirements
Module: qarctan_two_inputs

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of both operands and of the result.
REQ-002 Parameter BITS, default 10, fixed-point fraction bits; QUANT_VAL = 2^BITS.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 inA_rd_en  out  1  pop strobe for the A FIFO (y operand).
REQ-007 inA_empty  in  1  A FIFO empty.
REQ-008 inA_dout  in  DATA_WIDTH  signed y operand, first-word-fall-through.
REQ-009 inB_rd_en  out  1  pop strobe for the B FIFO (x operand).
REQ-010 inB_empty  in  1  B FIFO empty.
REQ-011 inB_dout  in  DATA_WIDTH  signed x operand, first-word-fall-through.
REQ-012 out_wr_en  out  1  push strobe to the output FIFO.
REQ-013 out_full  in  1  output FIFO full.
REQ-014 out_din  out  DATA_WIDTH  signed angle result.

Function
REQ-015 The block SHALL compute angle = qarctan(y=A, x=B) in BITS-fraction fixed point, with QUAD1 = 804 and QUAD3 = 2412.
REQ-016 The block SHALL form abs_y = |y| + 1 in 32-bit two's-complement wrapping arithmetic.
REQ-017 If x >= 0, the block SHALL compute r = ((x - abs_y) << BITS) / (x + abs_y) and angle = QUAD1 - (QUAD1*r)/QUANT_VAL.
REQ-018 If x < 0, the block SHALL compute r = ((x + abs_y) << BITS) / (abs_y - x) and angle = QUAD3 - (QUAD1*r)/QUANT_VAL.
REQ-019 The result SHALL be -angle when y < 0, and angle otherwise.
REQ-020 All divisions SHALL be signed, truncating toward zero (C semantics).
REQ-021 All intermediate values SHALL be 32-bit wrapping.
REQ-022 A zero divisor SHALL yield a quotient of 0.
REQ-023 The FSM SHALL have states IDLE, SETUP, DIV, WRITE.
REQ-024 IDLE: when both inA_empty and inB_empty are 0, the block SHALL assert inA_rd_en and inB_rd_en together for exactly one cycle, latch both operands, and go to SETUP.
REQ-025 The block SHALL never pop only one of the two FIFOs.
REQ-026 SETUP: the block SHALL form the numerator and denominator, start the divider, and go to DIV.
REQ-027 DIV: when the divider signals done, the block SHALL compute the angle and go to WRITE.
REQ-028 WRITE: while out_full is 1, the block SHALL hold out_din stable with out_wr_en = 0.
REQ-029 WRITE: when out_full is 0, the block SHALL assert out_wr_en for exactly one cycle and return to IDLE.
REQ-030 Latency from pop to write SHALL be at most DATA_WIDTH+4 cycles when not back-pressured.
REQ-031 Results SHALL be written in input order, one result per operand pair, none dropped or duplicated.
REQ-032 rd_en SHALL never assert while the corresponding empty is 1.
REQ-033 out_wr_en SHALL never assert while out_full is 1.

Reset
REQ-034 During reset, the state SHALL be IDLE, and inA_rd_en, inB_rd_en and out_wr_en SHALL be 0.
REQ-035 During reset, out_din and all internal registers SHALL be 0.
REQ-036 Reset at any point mid-operation SHALL abort the computation in progress, discard it, and emit no write.

Configuration
REQ-037 Macro QARCTAN_ASSERT_EN defined: the block SHALL include simulation-only assertions for REQ-025, REQ-032 and REQ-033, and for no write without a preceding pop.
REQ-038 Macro QARCTAN_ASSERT_EN undefined: the assertions SHALL be absent, with identical functional behaviour.

Structure
REQ-039 Package qarctan_pkg SHALL hold QUAD1, QUAD3, the default BITS, and the FSM state enum typedef.
REQ-040 The block SHALL contain one sub-module, qarctan_div: an iterative signed restoring divider with a start/done handshake.
REQ-041 qarctan_div SHALL take 32 iterations, truncate toward zero, and return 0 on a zero divisor.
REQ-042 fifo SHALL be an existing shared component, reused unchanged.

Verification
REQ-043 Input A=0, B=1 -> output 804.
REQ-044 Input A=1, B=0 -> output 1608.
REQ-045 Input A=-1, B=0 -> output -1608.
REQ-046 Input A=0, B=-1 -> output 2412.
REQ-047 Input A=100, B=100 -> output 807 (r=-5, (804*-5)/1024=-3).
REQ-048 Stream of 256 pairs with out_full held high for 100 cycles mid-stream -> all results in order, zero mismatches against the C reference model, and no write while full.
REQ-049 Reset asserted during DIV -> no output produced, next pair processed correctly after reset.

Source files
------------

// File: rtl/qarctan_pkg.sv
// qarctan_pkg: shared constants and FSM state type for the two-input
// fixed-point arctangent block.
//   QUAD1        - angle of the first quadrant boundary (pi/4 scaled by 2^10)
//   QUAD3        - 3 * QUAD1
//   DEFAULT_BITS - default number of fraction bits
//   qarctan_state_e - controller states
package qarctan_pkg;

  localparam int QUAD1        = 804;
  localparam int QUAD3        = 2412;
  localparam int DEFAULT_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DIV   = 2'd2,
    ST_WRITE = 2'd3
  } qarctan_state_e;

endpackage

// File: rtl/qarctan_div.sv
// qarctan_div: iterative signed restoring divider, one quotient bit per cycle.
// The quotient truncates toward zero; a zero divisor yields 0.
// Ports:
//   clock, reset     - rising-edge clock, synchronous active-high reset
//   start            - one-cycle pulse that loads dividend/divisor
//   dividend/divisor - signed operands, sampled on start
//   done             - one-cycle pulse, quotient valid while high and after
//   quotient         - signed result
module qarctan_div #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] dividend,
  input  logic signed [DATA_WIDTH-1:0] divisor,
  output logic                         done,
  output logic signed [DATA_WIDTH-1:0] quotient
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] rem_q, quo_q, den_q;
  logic                  neg_q, zero_q, busy_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [DATA_WIDTH-1:0] abs_n, abs_d, rem_next, quo_next;
  logic [DATA_WIDTH:0]   rem_shift, rem_sub;

  // Reapplies the operand sign to the magnitude quotient.
  function automatic logic signed [DATA_WIDTH-1:0] apply_sign(
    input logic [DATA_WIDTH-1:0] mag, input logic neg, input logic zero);
    if (zero)
      return '0;
    if (neg)
      return -$signed(mag);
    return $signed(mag);
  endfunction

  always_comb begin
    abs_n     = dividend[DATA_WIDTH-1] ? -dividend : dividend;
    abs_d     = divisor[DATA_WIDTH-1]  ? -divisor  : divisor;
    // The dividend sits in quo_q and shifts out MSB-first into the remainder.
    rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, den_q};
    if (!rem_sub[DATA_WIDTH]) begin
      rem_next = rem_sub[DATA_WIDTH-1:0];
      quo_next = {quo_q[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[DATA_WIDTH-1:0];
      quo_next = {quo_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q    <= '0;
      quo_q    <= '0;
      den_q    <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q  <= '0;
        quo_q  <= abs_n;
        den_q  <= abs_d;
        neg_q  <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
        zero_q <= (divisor == '0);
        busy_q <= 1'b1;
        cnt_q  <= '0;
      end else if (busy_q) begin
        rem_q <= rem_next;
        quo_q <= quo_next;
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
          busy_q   <= 1'b0;
          done     <= 1'b1;
          quotient <= apply_sign(quo_next, neg_q, zero_q);
        end
      end
    end
  end

endmodule

// File: rtl/qarctan_two_inputs.sv
// qarctan_two_inputs: pops (y, x) pairs from two first-word-fall-through
// FIFOs, computes the fixed-point quadrant arctangent of y/x and pushes the
// angle to an output FIFO. One pair in flight at a time, results in order.
// Ports:
//   clock, reset              - rising-edge clock, synchronous active-high reset
//   inA_rd_en/empty/dout      - y operand FIFO (pop strobe, empty flag, data)
//   inB_rd_en/empty/dout      - x operand FIFO
//   out_wr_en/full/din        - result FIFO (push strobe, full flag, data)
// Optional build macro: QARCTAN_ASSERT_EN adds simulation-only handshake
// assertions; behaviour is otherwise identical.
module qarctan_two_inputs
  import qarctan_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = DEFAULT_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  inA_rd_en,
  input  logic                  inA_empty,
  input  logic [DATA_WIDTH-1:0] inA_dout,
  output logic                  inB_rd_en,
  input  logic                  inB_empty,
  input  logic [DATA_WIDTH-1:0] inB_dout,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [DATA_WIDTH-1:0] out_din
);

  localparam logic signed [DATA_WIDTH-1:0] QUAD1_W  = DATA_WIDTH'(QUAD1);
  localparam logic signed [DATA_WIDTH-1:0] QUAD3_W  = DATA_WIDTH'(QUAD3);
  localparam logic signed [DATA_WIDTH-1:0] ONE_W    = DATA_WIDTH'(1);
  localparam logic signed [DATA_WIDTH-1:0] QUANT_M1 = DATA_WIDTH'((1 << BITS) - 1);

  qarctan_state_e state_q;

  logic signed [DATA_WIDTH-1:0] y_q, x_q;
  logic signed [DATA_WIDTH-1:0] abs_y, num, den, base, angle, result, div_q;
  logic                         div_start, div_done, pop;

  // Signed divide by 2^BITS, truncating toward zero.
  function automatic logic signed [DATA_WIDTH-1:0] div_quant(
    input logic signed [DATA_WIDTH-1:0] v);
    if (v < 0)
      return (v + QUANT_M1) >>> BITS;
    return v >>> BITS;
  endfunction

  // Both FIFOs are popped together or not at all; reset blocks all strobes.
  assign pop       = !reset && (state_q == ST_IDLE) && !inA_empty && !inB_empty;
  assign inA_rd_en = pop;
  assign inB_rd_en = pop;
  assign out_wr_en = !reset && (state_q == ST_WRITE) && !out_full;
  assign div_start = (state_q == ST_SETUP);

  always_comb begin
    abs_y = (y_q[DATA_WIDTH-1] ? -y_q : y_q) + ONE_W;
    if (!x_q[DATA_WIDTH-1]) begin
      num  = (x_q - abs_y) <<< BITS;
      den  = x_q + abs_y;
      base = QUAD1_W;
    end else begin
      num  = (x_q + abs_y) <<< BITS;
      den  = abs_y - x_q;
      base = QUAD3_W;
    end
    angle  = base - div_quant(QUAD1_W * div_q);
    result = y_q[DATA_WIDTH-1] ? -angle : angle;
  end

  qarctan_div #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_div (
    .clock   (clock),
    .reset   (reset),
    .start   (div_start),
    .dividend(num),
    .divisor (den),
    .done    (div_done),
    .quotient(div_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      x_q     <= '0;
      out_din <= '0;
    end else begin
      unique case (state_q)
        // Operand capture: FIFO heads are visible before the pop.
        ST_IDLE: begin
          if (pop) begin
            y_q     <= inA_dout;
            x_q     <= inB_dout;
            state_q <= ST_SETUP;
          end
        end
        // Numerator/denominator are formed combinationally; divider starts.
        ST_SETUP: state_q <= ST_DIV;
        // Quotient ready: finish the angle and hold it for the write.
        ST_DIV: begin
          if (div_done) begin
            out_din <= result;
            state_q <= ST_WRITE;
          end
        end
        // Output push, stalled while the result FIFO is full.
        ST_WRITE: begin
          if (!out_full)
            state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef QARCTAN_ASSERT_EN
  logic pending_q;

  always_ff @(posedge clock) begin
    if (reset)
      pending_q <= 1'b0;
    else if (pop)
      pending_q <= 1'b1;
    else if (out_wr_en)
      pending_q <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (inA_rd_en == inB_rd_en)
        else $error("qarctan: unpaired FIFO pop");
      assert (!(inA_rd_en && inA_empty))
        else $error("qarctan: A popped while empty");
      assert (!(inB_rd_en && inB_empty))
        else $error("qarctan: B popped while empty");
      assert (!(out_wr_en && out_full))
        else $error("qarctan: write while output full");
      assert (!out_wr_en || pending_q)
        else $error("qarctan: write without a preceding pop");
    end
  end
`endif

endmodule

// File: tb/tb_qarctan_two_inputs.sv
module tb_qarctan_two_inputs;

  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          inA_rd_en, inA_empty;
  logic [DW-1:0] inA_dout;
  logic          inB_rd_en, inB_empty;
  logic [DW-1:0] inB_dout;
  logic          out_wr_en, out_full;
  logic [DW-1:0] out_din;

  always #5 clock = ~clock;

  qarctan_two_inputs #(.DATA_WIDTH(DW), .BITS(10)) dut (
    .clock    (clock),
    .reset    (reset),
    .inA_rd_en(inA_rd_en),
    .inA_empty(inA_empty),
    .inA_dout (inA_dout),
    .inB_rd_en(inB_rd_en),
    .inB_empty(inB_empty),
    .inB_dout (inB_dout),
    .out_wr_en(out_wr_en),
    .out_full (out_full),
    .out_din  (out_din)
  );

  int  qa[$];
  int  qb[$];
  int  exp_q[$];
  int  pop_cyc[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cyc        = 0;
  int  writes     = 0;
  int  pops       = 0;
  bit  full_drv   = 1'b0;
  bit  check_lat  = 1'b1;

  // Reference: quadrant arctangent with C-style 32-bit integer arithmetic.
  function automatic int ref_angle(int y, int x);
    int abs_y, num, den, r, base, angle;
    abs_y = ((y < 0) ? -y : y) + 1;
    if (x >= 0) begin
      num  = int'(longint'(x - abs_y) * 1024);
      den  = x + abs_y;
      base = 804;
    end else begin
      num  = int'(longint'(x + abs_y) * 1024);
      den  = abs_y - x;
      base = 2412;
    end
    r     = (den == 0) ? 0 : int'(longint'(num) / longint'(den));
    angle = base - (804 * r) / 1024;
    return (y < 0) ? -angle : angle;
  endfunction

  task automatic check(string tag, longint obs, longint expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive_inputs();
    inA_empty = (qa.size() == 0);
    inB_empty = (qb.size() == 0);
    inA_dout  = (qa.size() != 0) ? qa[0] : 0;
    inB_dout  = (qb.size() != 0) ? qb[0] : 0;
    out_full  = full_drv;
  endtask

  task automatic push_pair(int y, int x);
    qa.push_back(y);
    qb.push_back(x);
    exp_q.push_back(ref_angle(y, x));
    drive_inputs();
  endtask

  // One clock: sample strobes mid-cycle, then model the FIFOs after the edge.
  task automatic tick();
    logic pa, pb, wr, fl;
    logic [DW-1:0] dout;
    int lat, e;
    @(negedge clock);
    pa = inA_rd_en; pb = inB_rd_en; wr = out_wr_en; fl = out_full; dout = out_din;
    if (pa || pb) begin
      check("paired_pop", pa, pb);
      if (pa) check("popA_not_empty", inA_empty, 0);
      if (pb) check("popB_not_empty", inB_empty, 0);
      pop_cyc.push_back(cyc);
      pops++;
    end
    if (fl) check("no_write_while_full", wr, 0);
    if (wr) begin
      writes++;
      check("write_has_expectation", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_din", longint'($signed(dout)), e);
      end
      if (pop_cyc.size() > 0) begin
        lat = cyc - pop_cyc.pop_front();
        if (check_lat) check("latency_bound", lat <= DW + 4, 1);
      end
    end
    @(posedge clock);
    cyc++;
    #1;
    if (pa && qa.size() > 0) void'(qa.pop_front());
    if (pb && qb.size() > 0) void'(qb.pop_front());
    drive_inputs();
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || qa.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_budget", n < budget, 1);
  endtask

  function automatic int rand_val();
    int sel;
    sel = int'($urandom_range(0, 3));
    case (sel)
      0: return int'($urandom);
      1: return int'($urandom_range(0, 4000)) - 2000;
      2: begin
        int picks[5];
        picks[0] = 32'sh80000000; picks[1] = 32'sh7fffffff;
        picks[2] = 0; picks[3] = -1; picks[4] = 1;
        return picks[$urandom_range(0, 4)];
      end
      default: return int'($urandom_range(0, 2097152)) - 1048576;
    endcase
  endfunction

  initial begin
    int w0, n, p0;
    int imin, imax;
    imin = 32'sh80000000;
    imax = 32'sh7fffffff;

    // Reset with a pair already waiting: no pops, no writes, zero output.
    reset = 1'b1;
    full_drv = 1'b0;
    drive_inputs();
    push_pair(0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_rdA", inA_rd_en, 0);
      check("rst_rdB", inB_rd_en, 0);
      check("rst_wr", out_wr_en, 0);
      check("rst_dout", out_din, 0);
      @(posedge clock);
      cyc++;
      #1;
    end
    reset = 1'b0;

    // Directed vectors, including zero-divisor and extreme operands.
    drain(100);
    push_pair(1, 0);    drain(100);
    push_pair(-1, 0);   drain(100);
    push_pair(0, -1);   drain(100);
    push_pair(100, 100); drain(100);
    check("ref_100_100", ref_angle(100, 100), 807);
    check("ref_m1_0", ref_angle(-1, 0), -1608);
    push_pair(imin, imax);      drain(100);
    push_pair(imin, imin + 1);  drain(100);
    push_pair(imax, imin);      drain(100);
    push_pair(-5000, 3);        drain(100);

    // Random stream with a long output stall in the middle.
    check_lat = 1'b0;
    w0 = writes;
    for (int i = 0; i < 256; i++) push_pair(rand_val(), rand_val());
    n = 0;
    while (exp_q.size() != 0 && n < 12000) begin
      if (n == 3000) full_drv = 1'b1;
      if (n == 3100) full_drv = 1'b0;
      drive_inputs();
      tick();
      n++;
    end
    full_drv = 1'b0;
    drive_inputs();
    check("stream_in_budget", n < 12000, 1);
    check("stream_count", writes - w0, 256);
    check_lat = 1'b1;

    // Reset while dividing: the pair is discarded and nothing is written.
    p0 = pops;
    push_pair(123, -456);
    n = 0;
    while (pops == p0 && n < 20) begin tick(); n++; end
    check("abort_pair_popped", pops - p0, 1);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (pop_cyc.size() > 0) void'(pop_cyc.pop_front());
    w0 = writes;
    repeat (60) tick();
    check("no_write_after_abort", writes - w0, 0);
    push_pair(-777, 333);
    drain(100);
    check("post_abort_count", writes - w0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
